axis_frame_accumulator: RTL and testbench

- Parametrised successor to the single-stream accumulator.
- Sums a frame of signed AXI-Stream samples and emits one result beat per frame.
- A frame ends at a runtime-programmable beat count or at an early s_axis_tlast, whichever comes first.
- Adds selectable saturating or wrapping arithmetic, an overflow flag, output backpressure handling and an output tlast. Sits between the DMA MM2S stream and the S2MM stream.

---
 rtl/axis_frame_accumulator.sv | 186 ++++++++++++++++++
 tb/tb_axis_frame_accumulator.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_accumulator.sv
// -----------------------------------------------------------------------------
// axis_frame_accumulator
//
// Sums a frame of signed AXI-Stream samples. It emits one result beat per
// frame. A frame ends after a programmable number of beats or at an early
// s_axis_tlast, whichever comes first. Arithmetic can saturate or wrap. Any
// overflow inside the frame is reported on m_axis_tuser with the result.
//
// Parameters
//   DATA_W   input sample width (signed)
//   ACC_W    accumulator / result width (signed), ACC_W >= DATA_W
//   CNT_W    width of the beat counter and cfg_frame_len
//   SATURATE 1 = clamp on overflow, 0 = two's-complement wrap
//
// Ports
//   sys_clk, sys_rst_n     clock (rising edge), async active-low reset
//   accu_en                level enable; a frame starts only while high
//   cfg_frame_len          beats per frame, sampled when a frame starts (0 -> 1)
//   accu_finished          one-cycle pulse after the result beat handshakes
//   accu_busy              high while accumulating or holding the result
//   s_axis_*               sample input stream (tvalid/tready/tdata/tlast)
//   m_axis_*               result stream; tlast always 1 with tvalid,
//                          tuser = overflow seen in this frame
// -----------------------------------------------------------------------------
module axis_frame_accumulator #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ACC_W    = 64,
   parameter int unsigned CNT_W    = 16,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              accu_en,
   input  logic [CNT_W-1:0]  cfg_frame_len,
   output logic              accu_finished,
   output logic              accu_busy,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [ACC_W-1:0]  m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CNT_W-1:0]   len, len_nxt;
   logic               ovf, ovf_nxt;

   logic               s_tready_nxt;
   logic               m_tvalid_nxt;
   logic [ACC_W-1:0]   m_tdata_nxt;
   logic               m_tlast_nxt;
   logic               m_tuser_nxt;
   logic               finished_nxt;
   logic               busy_nxt;

   logic [ACC_W-1:0]   sample_ext;
   logic [ACC_W-1:0]   sum_raw;
   logic [ACC_W-1:0]   sum_sel;
   logic               beat_ovf;
   logic [CNT_W-1:0]   len_cfg;
   logic               last_beat;

   // Datapath: sign-extend the sample, add, and detect overflow from the signs.
   // Overflow means both operands have the same sign and the result sign differs.
   always_comb begin
      sample_ext = ACC_W'($signed(s_axis_tdata));
      sum_raw    = acc + sample_ext;
      beat_ovf   = (acc[ACC_W-1] == sample_ext[ACC_W-1]) &&
                   (sum_raw[ACC_W-1] != acc[ACC_W-1]);
      sum_sel    = sum_raw;
      if (SATURATE && beat_ovf) begin
         // The clamp direction follows the common operand sign.
         sum_sel = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end
      len_cfg   = (cfg_frame_len == '0) ? CNT_W'(1) : cfg_frame_len;
      last_beat = (cnt == (len - CNT_W'(1))) || s_axis_tlast;
   end

   // Next-state and next-output logic. All outputs are registered.
   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      cnt_nxt      = cnt;
      len_nxt      = len;
      ovf_nxt      = ovf;
      s_tready_nxt = s_axis_tready;
      m_tvalid_nxt = m_axis_tvalid;
      m_tdata_nxt  = m_axis_tdata;
      m_tlast_nxt  = m_axis_tlast;
      m_tuser_nxt  = m_axis_tuser;
      finished_nxt = 1'b0;
      busy_nxt     = accu_busy;

      case (state)
         IDLE: begin
            s_tready_nxt = 1'b0;
            if (accu_en) begin
               len_nxt      = len_cfg;
               acc_nxt      = '0;
               cnt_nxt      = '0;
               ovf_nxt      = 1'b0;
               s_tready_nxt = 1'b1;
               busy_nxt     = 1'b1;
               state_nxt    = ACCUM;
            end
         end

         ACCUM: begin
            if (s_axis_tvalid && s_axis_tready) begin
               acc_nxt = sum_sel;
               cnt_nxt = cnt + CNT_W'(1);
               ovf_nxt = ovf | beat_ovf;
               if (last_beat) begin
                  m_tdata_nxt  = sum_sel;
                  m_tvalid_nxt = 1'b1;
                  m_tlast_nxt  = 1'b1;
                  m_tuser_nxt  = ovf | beat_ovf;
                  s_tready_nxt = 1'b0;
                  state_nxt    = OUTPUT;
               end
            end
         end

         OUTPUT: begin
            // tdata and tuser hold their values until the handshake.
            if (m_axis_tvalid && m_axis_tready) begin
               m_tvalid_nxt = 1'b0;
               m_tlast_nxt  = 1'b0;
               finished_nxt = 1'b1;
               busy_nxt     = 1'b0;
               state_nxt    = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         len           <= '0;
         ovf           <= 1'b0;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         accu_finished <= 1'b0;
         accu_busy     <= 1'b0;
      end else begin
         state         <= state_nxt;
         acc           <= acc_nxt;
         cnt           <= cnt_nxt;
         len           <= len_nxt;
         ovf           <= ovf_nxt;
         s_axis_tready <= s_tready_nxt;
         m_axis_tvalid <= m_tvalid_nxt;
         m_axis_tdata  <= m_tdata_nxt;
         m_axis_tlast  <= m_tlast_nxt;
         m_axis_tuser  <= m_tuser_nxt;
         accu_finished <= finished_nxt;
         accu_busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_axis_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_accumulator
//
// Three instances share one set of stimulus: a 64-bit saturating unit, an
// 8-bit saturating unit and an 8-bit wrapping unit. The 8-bit units take the
// low byte of the shared sample bus. Inputs are driven on the falling edge.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_frame_accumulator;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        accu_en;
   logic [15:0] cfg_frame_len;
   logic        s_tvalid;
   logic [63:0] s_tdata;
   logic        s_tlast;
   logic        m_tready;

   logic        s_tready0, m_tvalid0, m_tlast0, m_tuser0, fin0, busy0;
   logic [63:0] m_tdata0;
   logic        s_tready1, m_tvalid1, m_tlast1, m_tuser1, fin1, busy1;
   logic [7:0]  m_tdata1;
   logic        s_tready2, m_tvalid2, m_tlast2, m_tuser2, fin2, busy2;
   logic [7:0]  m_tdata2;

   int unsigned passed;
   int unsigned total;

   axis_frame_accumulator #(
      .DATA_W(64), .ACC_W(64), .CNT_W(16), .SATURATE(1'b1)
   ) dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .accu_en(accu_en),
      .cfg_frame_len(cfg_frame_len), .accu_finished(fin0), .accu_busy(busy0),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
      .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata0), .m_axis_tlast(m_tlast0), .m_axis_tuser(m_tuser0)
   );

   axis_frame_accumulator #(
      .DATA_W(8), .ACC_W(8), .CNT_W(16), .SATURATE(1'b1)
   ) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .accu_en(accu_en),
      .cfg_frame_len(cfg_frame_len), .accu_finished(fin1), .accu_busy(busy1),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
      .s_axis_tdata(s_tdata[7:0]), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata1), .m_axis_tlast(m_tlast1), .m_axis_tuser(m_tuser1)
   );

   axis_frame_accumulator #(
      .DATA_W(8), .ACC_W(8), .CNT_W(16), .SATURATE(1'b0)
   ) dut2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .accu_en(accu_en),
      .cfg_frame_len(cfg_frame_len), .accu_finished(fin2), .accu_busy(busy2),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
      .s_axis_tdata(s_tdata[7:0]), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata2), .m_axis_tlast(m_tlast2), .m_axis_tuser(m_tuser2)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Offers one beat and returns on the falling edge after it is accepted.
   task automatic send(input logic [63:0] d, input logic l);
      int unsigned n;
      n        = 0;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      while (!s_tready0 && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      if (n >= 20) begin
         total++;
         $display("FAIL send_timeout: s_axis_tready stayed %b, required 1", s_tready0);
      end
      @(negedge sys_clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic start_frame(input logic [15:0] len);
      cfg_frame_len = len;
      accu_en       = 1'b1;
      @(negedge sys_clk);
      accu_en       = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      total++;
      if ({s_tready0, m_tvalid0, m_tlast0, m_tuser0, fin0, busy0} !== 6'b0)
         $display("FAIL reset_ctrl: got %b required 000000",
                  {s_tready0, m_tvalid0, m_tlast0, m_tuser0, fin0, busy0});
      else passed++;
      total++;
      if (m_tdata0 !== 64'd0 || m_tdata1 !== 8'd0 || m_tdata2 !== 8'd0)
         $display("FAIL reset_tdata: got %h/%h/%h required 0", m_tdata0, m_tdata1, m_tdata2);
      else passed++;
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_basic();
      start_frame(16'd4);
      total++;
      if (s_tready0 !== 1'b1 || busy0 !== 1'b1)
         $display("FAIL basic_ready: got tready=%b busy=%b required 1/1", s_tready0, busy0);
      else passed++;
      send(64'd10, 1'b0);
      send(64'd20, 1'b0);
      send(-64'sd5, 1'b0);
      send(64'd7, 1'b0);
      total++;
      if (m_tvalid0 !== 1'b1 || m_tdata0 !== 64'd32 || m_tlast0 !== 1'b1 ||
          m_tuser0 !== 1'b0 || s_tready0 !== 1'b0 || fin0 !== 1'b0)
         $display("FAIL basic_result: got v=%b d=%0d l=%b u=%b rdy=%b fin=%b required 1 32 1 0 0 0",
                  m_tvalid0, $signed(m_tdata0), m_tlast0, m_tuser0, s_tready0, fin0);
      else passed++;
      @(negedge sys_clk);
      total++;
      if (fin0 !== 1'b1 || m_tvalid0 !== 1'b0 || busy0 !== 1'b0)
         $display("FAIL basic_finish: got fin=%b v=%b busy=%b required 1 0 0", fin0, m_tvalid0, busy0);
      else passed++;
      @(negedge sys_clk);
      total++;
      if (fin0 !== 1'b0 || s_tready0 !== 1'b0)
         $display("FAIL basic_fin_once: got fin=%b rdy=%b required 0 0", fin0, s_tready0);
      else passed++;
   endtask

   task automatic test_early_tlast();
      start_frame(16'd8);
      send(64'd1, 1'b0);
      send(64'd2, 1'b0);
      send(64'd3, 1'b1);
      total++;
      if (m_tvalid0 !== 1'b1 || m_tdata0 !== 64'd6 || s_tready0 !== 1'b0)
         $display("FAIL early_result: got v=%b d=%0d rdy=%b required 1 6 0",
                  m_tvalid0, $signed(m_tdata0), s_tready0);
      else passed++;
      repeat (3) @(negedge sys_clk);
      total++;
      if (s_tready0 !== 1'b0 || m_tvalid0 !== 1'b0)
         $display("FAIL early_idle: got rdy=%b v=%b required 0 0", s_tready0, m_tvalid0);
      else passed++;
   endtask

   task automatic test_back_to_back();
      cfg_frame_len = 16'd2;
      accu_en       = 1'b1;
      @(negedge sys_clk);
      send(64'd3, 1'b0);
      send(64'd4, 1'b0);
      total++;
      if (m_tvalid0 !== 1'b1 || m_tdata0 !== 64'd7)
         $display("FAIL b2b_first: got v=%b d=%0d required 1 7", m_tvalid0, $signed(m_tdata0));
      else passed++;
      @(negedge sys_clk);
      total++;
      if (s_tready0 !== 1'b0 || fin0 !== 1'b1 || m_tvalid0 !== 1'b0)
         $display("FAIL b2b_gap: got rdy=%b fin=%b v=%b required 0 1 0", s_tready0, fin0, m_tvalid0);
      else passed++;
      @(negedge sys_clk);
      total++;
      if (s_tready0 !== 1'b1 || fin0 !== 1'b0 || busy0 !== 1'b1)
         $display("FAIL b2b_restart: got rdy=%b fin=%b busy=%b required 1 0 1", s_tready0, fin0, busy0);
      else passed++;
      cfg_frame_len = 16'd8;     // must not affect the running frame
      send(64'd5, 1'b0);
      send(64'd5, 1'b0);
      accu_en = 1'b0;
      total++;
      if (m_tvalid0 !== 1'b1 || m_tdata0 !== 64'd10)
         $display("FAIL b2b_second: got v=%b d=%0d required 1 10", m_tvalid0, $signed(m_tdata0));
      else passed++;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic test_backpressure();
      m_tready = 1'b0;
      start_frame(16'd2);
      send(64'd5, 1'b0);
      send(64'd6, 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (m_tvalid0 !== 1'b1 || m_tdata0 !== 64'd11 || m_tlast0 !== 1'b1 ||
             s_tready0 !== 1'b0 || fin0 !== 1'b0)
            $display("FAIL bp_hold[%0d]: got v=%b d=%0d l=%b rdy=%b fin=%b required 1 11 1 0 0",
                     i, m_tvalid0, $signed(m_tdata0), m_tlast0, s_tready0, fin0);
         else passed++;
         @(negedge sys_clk);
      end
      m_tready = 1'b1;
      @(negedge sys_clk);
      total++;
      if (m_tvalid0 !== 1'b0 || fin0 !== 1'b1)
         $display("FAIL bp_release: got v=%b fin=%b required 0 1", m_tvalid0, fin0);
      else passed++;
      @(negedge sys_clk);
      total++;
      if (fin0 !== 1'b0)
         $display("FAIL bp_fin_once: got fin=%b required 0", fin0);
      else passed++;
   endtask

   task automatic test_saturation();
      // 100 + 100: saturates to 127, wraps to -56, fits in 64 bits
      start_frame(16'd2);
      send(64'd100, 1'b0);
      send(64'd100, 1'b0);
      total++;
      if (m_tdata1 !== 8'h7F || m_tuser1 !== 1'b1)
         $display("FAIL sat_pos: got d=%0d u=%b required 127 1", $signed(m_tdata1), m_tuser1);
      else passed++;
      total++;
      if (m_tdata2 !== 8'hC8 || m_tuser2 !== 1'b1)
         $display("FAIL wrap_pos: got d=%0d u=%b required -56 1", $signed(m_tdata2), m_tuser2);
      else passed++;
      total++;
      if (m_tdata0 !== 64'd200 || m_tuser0 !== 1'b0)
         $display("FAIL wide_pos: got d=%0d u=%b required 200 0", $signed(m_tdata0), m_tuser0);
      else passed++;
      repeat (2) @(negedge sys_clk);

      // -100 + -100: saturates to -128, wraps to 56
      start_frame(16'd2);
      send(-64'sd100, 1'b0);
      send(-64'sd100, 1'b0);
      total++;
      if (m_tdata1 !== 8'h80 || m_tuser1 !== 1'b1)
         $display("FAIL sat_neg: got d=%0d u=%b required -128 1", $signed(m_tdata1), m_tuser1);
      else passed++;
      total++;
      if (m_tdata2 !== 8'h38 || m_tuser2 !== 1'b1)
         $display("FAIL wrap_neg: got d=%0d u=%b required 56 1", $signed(m_tdata2), m_tuser2);
      else passed++;
      total++;
      if (m_tdata0 !== 64'hFFFF_FFFF_FFFF_FF38)
         $display("FAIL wide_neg: got d=%0d required -200", $signed(m_tdata0));
      else passed++;
      repeat (2) @(negedge sys_clk);

      // Continues from the clamped value: 127 - 1 = 126, wrap -56 - 1 = -57
      start_frame(16'd3);
      send(64'd100, 1'b0);
      send(64'd100, 1'b0);
      send(-64'sd1, 1'b0);
      total++;
      if (m_tdata1 !== 8'd126 || m_tuser1 !== 1'b1 || m_tdata2 !== 8'hC7 || m_tuser2 !== 1'b1)
         $display("FAIL sat_continue: got sat=%0d/%b wrap=%0d/%b required 126/1 -57/1",
                  $signed(m_tdata1), m_tuser1, $signed(m_tdata2), m_tuser2);
      else passed++;
      total++;
      if (m_tdata0 !== 64'd199)
         $display("FAIL wide_continue: got d=%0d required 199", $signed(m_tdata0));
      else passed++;
      repeat (2) @(negedge sys_clk);

      // Clean frame after overflow: flag cleared; tlast on the final beat is normal
      start_frame(16'd2);
      send(64'd1, 1'b0);
      send(64'd1, 1'b1);
      total++;
      if (m_tdata1 !== 8'd2 || m_tuser1 !== 1'b0 || m_tdata2 !== 8'd2 || m_tuser2 !== 1'b0 ||
          m_tvalid1 !== 1'b1)
         $display("FAIL sat_clear: got sat=%0d/%b wrap=%0d/%b v=%b required 2/0 2/0 1",
                  $signed(m_tdata1), m_tuser1, $signed(m_tdata2), m_tuser2, m_tvalid1);
      else passed++;
      @(negedge sys_clk);
      total++;
      if (fin1 !== 1'b1 || fin2 !== 1'b1 || m_tvalid1 !== 1'b0)
         $display("FAIL sat_finish: got fin=%b/%b v=%b required 1/1 0", fin1, fin2, m_tvalid1);
      else passed++;
      repeat (2) @(negedge sys_clk);
      total++;
      if (s_tready1 !== 1'b0 || busy1 !== 1'b0 || m_tvalid1 !== 1'b0)
         $display("FAIL sat_no_extra: got rdy=%b busy=%b v=%b required 0 0 0", s_tready1, busy1, m_tvalid1);
      else passed++;
   endtask

   task automatic test_reset_len0();
      start_frame(16'd4);
      send(64'd10, 1'b0);
      send(64'd20, 1'b0);
      sys_rst_n = 1'b0;
      #1;
      total++;
      if ({s_tready0, m_tvalid0, m_tlast0, m_tuser0, fin0, busy0} !== 6'b0 ||
          m_tdata0 !== 64'd0 || m_tdata1 !== 8'd0)
         $display("FAIL midreset: got ctrl=%b d=%0d required 000000 0",
                  {s_tready0, m_tvalid0, m_tlast0, m_tuser0, fin0, busy0}, $signed(m_tdata0));
      else passed++;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      start_frame(16'd0);
      send(64'd9, 1'b0);
      total++;
      if (m_tvalid0 !== 1'b1 || m_tdata0 !== 64'd9 || m_tlast0 !== 1'b1)
         $display("FAIL len0_result: got v=%b d=%0d l=%b required 1 9 1",
                  m_tvalid0, $signed(m_tdata0), m_tlast0);
      else passed++;
      @(negedge sys_clk);
      total++;
      if (fin0 !== 1'b1)
         $display("FAIL len0_finish: got fin=%b required 1", fin0);
      else passed++;
   endtask

   initial begin
      passed        = 0;
      total         = 0;
      sys_rst_n     = 1'b0;
      accu_en       = 1'b0;
      cfg_frame_len = 16'd0;
      s_tvalid      = 1'b0;
      s_tdata       = 64'd0;
      s_tlast       = 1'b0;
      m_tready      = 1'b1;
      @(negedge sys_clk);
      test_reset();
      test_basic();
      test_early_tlast();
      test_back_to_back();
      test_backpressure();
      test_saturation();
      test_reset_len0();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
